// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard scoreboard.
// Slot record, select-width and latency clamp.
package hazard_pkg;

  localparam int RD_MAX_W = 8;

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic [3:0]          rem;
  } slot_t;

  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic logic [3:0] clamp_lat(
    input logic [3:0] lat,
    input int         depth
  );
    if (lat == 4'd0) return 4'd1;
    if (int'(lat) > depth) return 4'(depth);
    return lat;
  endfunction

endpackage

// File: rtl/hazard_slot_match.sv
// Youngest-match priority encoder over the slots.
// Returns slot index, readiness and hit for one source.
module hazard_slot_match
  import hazard_pkg::*;
#(
  parameter int RA_W  = 5,
  parameter int DEPTH = 4,
  parameter int SEL_W = 3
) (
  input  slot_t            slots_i [1:DEPTH],
  input  logic [RA_W-1:0]  src_i,
  input  logic             used_i,
  output logic [SEL_W-1:0] sel_o,
  output logic             ready_o,
  output logic             hit_o
);

  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    sel_o   = '0;
    ready_o = 1'b0;
    hit_o   = 1'b0;
    if (used_i && src_i != '0) begin
      for (int k = DEPTH; k >= 1; k--) begin
        if (slots_i[k].valid &&
            slots_i[k].rd == RD_MAX_W'(src_i)) begin
          hit_o   = 1'b1;
          sel_o   = SEL_W'(k);
          ready_o = (slots_i[k].rem == 4'd0);
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// In-flight result scoreboard for the ID stage.
// Detects RAW hazards, picks forwarding slots.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int RA_W  = 5,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      issue_valid,
  input  logic [RA_W-1:0]           issue_rs,
  input  logic [RA_W-1:0]           issue_rt,
  input  logic                      issue_rs_used,
  input  logic                      issue_rt_used,
  input  logic                      issue_wr,
  input  logic [RA_W-1:0]           issue_rd,
  input  logic [3:0]                issue_lat,
  input  logic                      flush,
  output logic                      stall,
  output logic                      issue_fire,
  output logic [sel_w(DEPTH)-1:0]   fwd_rs_sel,
  output logic [sel_w(DEPTH)-1:0]   fwd_rt_sel,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int SEL_W = sel_w(DEPTH);

  slot_t slot_q [1:DEPTH];
  slot_t slot_d [1:DEPTH];

  logic [SEL_W-1:0] rs_sel, rt_sel;
  logic             rs_rdy, rt_rdy;
  logic             rs_hit, rt_hit;
  logic             hazard;
  logic             rd_ok;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  hazard_slot_match #(
    .RA_W(RA_W), .DEPTH(DEPTH), .SEL_W(SEL_W)
  ) u_rs (
    .slots_i(slot_q), .src_i(issue_rs),
    .used_i(issue_rs_used), .sel_o(rs_sel),
    .ready_o(rs_rdy), .hit_o(rs_hit)
  );

  hazard_slot_match #(
    .RA_W(RA_W), .DEPTH(DEPTH), .SEL_W(SEL_W)
  ) u_rt (
    .slots_i(slot_q), .src_i(issue_rt),
    .used_i(issue_rt_used), .sel_o(rt_sel),
    .ready_o(rt_rdy), .hit_o(rt_hit)
  );

  // Outputs are gated by rst_n so reset silences them at once.
  assign hazard = (rs_hit & ~rs_rdy) | (rt_hit & ~rt_rdy);
  assign stall = rst_n & issue_valid & ~flush & hazard;
  assign issue_fire = rst_n & issue_valid & ~flush & ~hazard;
  assign fwd_rs_sel = (rst_n && rs_hit && rs_rdy) ? rs_sel : '0;
  assign fwd_rt_sel = (rst_n && rt_hit && rt_rdy) ? rt_sel : '0;
  assign stall_cnt = cnt_q;

  assign rd_ok = (issue_rd != '0) && (int'(issue_rd) < NREG);

  // Shift the pipe every cycle; slot 1 takes the issue or a bubble.
  always_comb begin
    slot_d[1] = '0;
    if (issue_fire) begin
      slot_d[1].valid = issue_wr & rd_ok;
      slot_d[1].rd    = RD_MAX_W'(issue_rd);
      slot_d[1].rem   = clamp_lat(issue_lat, DEPTH) - 4'd1;
    end
    for (int k = 2; k <= DEPTH; k++) begin
      slot_d[k] = slot_q[k-1];
      if (slot_q[k-1].rem != 4'd0)
        slot_d[k].rem = slot_q[k-1].rem - 4'd1;
    end
  end

  // Saturating stall counter next state.
  always_comb begin
    cnt_d = cnt_q;
    if (stall && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  // Slot pipe and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= DEPTH; k++) slot_q[k] <= '0;
      cnt_q <= '0;
    end else begin
      for (int k = 1; k <= DEPTH; k++) slot_q[k] <= slot_d[k];
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized and directed bench for hazard_scoreboard.
// Reference model: timestamped issue history.
module tb_hazard_scoreboard;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       issue_valid = 1'b0;
  logic [4:0] issue_rs = '0, issue_rt = '0, issue_rd = '0;
  logic       issue_rs_used = 1'b0, issue_rt_used = 1'b0;
  logic       issue_wr = 1'b0;
  logic [3:0] issue_lat = '0;
  logic       flush = 1'b0;
  logic       stall, issue_fire;
  logic [2:0] fwd_rs_sel, fwd_rt_sel;
  logic [15:0] stall_cnt;
  logic       s_stall, s_fire;
  logic [2:0] s_rs_sel, s_rt_sel;
  logic [1:0] s_cnt;

  always #5 clk = ~clk;

  hazard_scoreboard u_dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid),
    .issue_rs(issue_rs), .issue_rt(issue_rt),
    .issue_rs_used(issue_rs_used), .issue_rt_used(issue_rt_used),
    .issue_wr(issue_wr), .issue_rd(issue_rd), .issue_lat(issue_lat),
    .flush(flush), .stall(stall), .issue_fire(issue_fire),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .stall_cnt(stall_cnt)
  );

  hazard_scoreboard #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid),
    .issue_rs(issue_rs), .issue_rt(issue_rt),
    .issue_rs_used(issue_rs_used), .issue_rt_used(issue_rt_used),
    .issue_wr(issue_wr), .issue_rd(issue_rd), .issue_lat(issue_lat),
    .flush(flush), .stall(s_stall), .issue_fire(s_fire),
    .fwd_rs_sel(s_rs_sel), .fwd_rt_sel(s_rt_sel),
    .stall_cnt(s_cnt)
  );

  typedef struct {
    int rd;
    int t_iss;
    int lat;
  } hist_t;

  hist_t hist[$];
  int    now = 0;
  int    m_cnt = 0;
  int    n_chk = 0;
  int    n_pass = 0;
  int    o_stall, o_fire, o_rs, o_rt;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int eff_lat(input int lat);
    if (lat == 0) return 1;
    if (lat > DEPTH) return DEPTH;
    return lat;
  endfunction

  // Youngest in-flight writer of src decides: forward if its
  // latency has elapsed, otherwise the source must wait.
  task automatic src_model(input int src, input int used,
                           output int sel, output int wait_o);
    int best_age;
    int best_lat;
    sel = 0;
    wait_o = 0;
    best_age = 0;
    best_lat = 0;
    if (used != 0 && src != 0) begin
      foreach (hist[i]) begin
        int age;
        age = now - hist[i].t_iss;
        if (hist[i].rd == src && age >= 1 && age <= DEPTH &&
            (best_age == 0 || age < best_age)) begin
          best_age = age;
          best_lat = hist[i].lat;
        end
      end
      if (best_age != 0) begin
        if (best_age >= best_lat) sel = best_age;
        else wait_o = 1;
      end
    end
  endtask

  task automatic step(input int v, input int rs, input int rsu,
                      input int rt, input int rtu, input int wr,
                      input int rd, input int lat, input int fl);
    int sa, wa, sb, wb, m_stall, m_fire;
    issue_valid = v[0];
    issue_rs = rs[4:0];
    issue_rs_used = rsu[0];
    issue_rt = rt[4:0];
    issue_rt_used = rtu[0];
    issue_wr = wr[0];
    issue_rd = rd[4:0];
    issue_lat = lat[3:0];
    flush = fl[0];
    @(negedge clk);
    src_model(rs, rsu, sa, wa);
    src_model(rt, rtu, sb, wb);
    m_stall = (v != 0 && fl == 0 && (wa | wb) != 0) ? 1 : 0;
    m_fire = (v != 0 && fl == 0 && (wa | wb) == 0) ? 1 : 0;
    o_stall = int'(stall);
    o_fire = int'(issue_fire);
    o_rs = int'(fwd_rs_sel);
    o_rt = int'(fwd_rt_sel);
    check("stall", o_stall, m_stall);
    check("fire", o_fire, m_fire);
    check("rs_sel", o_rs, sa);
    check("rt_sel", o_rt, sb);
    check("cnt", int'(stall_cnt), m_cnt);
    check("cnt_sat", int'(s_cnt), m_cnt > 3 ? 3 : m_cnt);
    @(posedge clk);
    if (m_fire != 0 && wr != 0 && rd != 0)
      hist.push_back('{rd: rd, t_iss: now, lat: eff_lat(lat)});
    if (m_stall != 0) m_cnt++;
    now++;
    while (hist.size() > 0 && now - hist[0].t_iss > DEPTH)
      void'(hist.pop_front());
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int stalls;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", int'(stall), 0);
    check("rst_fire", int'(issue_fire), 0);
    check("rst_cnt", int'(stall_cnt), 0);
    rst_n = 1'b1;

    // Back-to-back forward from slot 1.
    step(1, 0, 0, 0, 0, 1, 3, 1, 0);
    step(1, 3, 1, 0, 0, 0, 0, 0, 0);
    check("d33_sel", o_rs, 1);
    check("d33_fire", o_fire, 1);
    idle(5);

    // Load-use: one bubble then slot 2.
    step(1, 0, 0, 0, 0, 1, 5, 2, 0);
    step(1, 5, 1, 0, 0, 0, 0, 0, 0);
    check("d34_stall", o_stall, 1);
    step(1, 5, 1, 0, 0, 0, 0, 0, 0);
    check("d34_sel", o_rs, 2);
    check("d34_cnt", int'(stall_cnt), 1);
    idle(5);

    // Multiply: three bubbles, forward from the last slot.
    step(1, 0, 0, 0, 0, 1, 9, 4, 0);
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, 9, 1, 0, 0, 0, 0);
      if (o_stall == 0) break;
      stalls++;
    end
    check("d35_stalls", stalls, 3);
    check("d35_sel", o_rt, 4);
    step(1, 0, 0, 9, 1, 0, 0, 0, 0);
    check("d35_gone", o_rt, 0);
    idle(5);

    // Youngest writer wins.
    step(1, 0, 0, 0, 0, 1, 7, 1, 0);
    step(1, 0, 0, 0, 0, 1, 7, 1, 0);
    step(1, 7, 1, 0, 0, 0, 0, 0, 0);
    check("d36_sel", o_rs, 1);
    idle(5);
    step(1, 0, 0, 0, 0, 1, 7, 1, 0);
    step(1, 0, 0, 0, 0, 1, 7, 3, 0);
    step(1, 7, 1, 0, 0, 0, 0, 0, 0);
    check("d36_stall", o_stall, 1);
    idle(5);

    // r0 never hazards; flush kills stall and fire.
    step(1, 0, 0, 0, 0, 1, 0, 3, 0);
    step(1, 0, 1, 0, 1, 0, 0, 0, 0);
    check("d37_r0", o_stall, 0);
    step(1, 0, 0, 0, 0, 1, 4, 3, 0);
    step(1, 4, 1, 0, 0, 1, 6, 1, 1);
    check("d37_fl_stall", o_stall, 0);
    check("d37_fl_fire", o_fire, 0);
    idle(5);

    // Asynchronous reset in the middle of a stall.
    step(1, 0, 0, 0, 0, 1, 10, 4, 0);
    issue_valid = 1'b1;
    issue_rs = 5'd10;
    issue_rs_used = 1'b1;
    issue_wr = 1'b0;
    @(negedge clk);
    check("d38_pre", int'(stall), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("d38_stall", int'(stall), 0);
    check("d38_fire", int'(issue_fire), 0);
    check("d38_sel", int'(fwd_rs_sel), 0);
    check("d38_cnt", int'(stall_cnt), 0);
    hist.delete();
    m_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 10, 1, 0, 0, 0, 0, 0, 0);
    check("d38_clear", o_stall, 0);

    // Random traffic over a small register window.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0 ? 1 : 0,
           $urandom_range(0, 7), $urandom % 2,
           $urandom_range(0, 7), $urandom % 2,
           $urandom % 2, $urandom_range(0, 7),
           $urandom_range(0, 7),
           ($urandom % 8) == 0 ? 1 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
